// File: rtl/servo_ramp.sv
// Slew-rate limiter: walks pitch/yaw positions toward a target pair by at most STEP_SIZE per frame tick.
// Latency: target accepted in 1 cycle; positions move only on tick edges; done one cycle after final step.
// Backpressure: tgt_ready is low while a ramp is running; requests are not queued, source must hold.
module servo_ramp #(
  parameter int STEP_DIV  = 1000000,
  parameter int STEP_SIZE = 4,
  parameter int RESET_POS = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_p,
  input  logic [7:0] tgt_y,
  output logic [7:0] pos_p,
  output logic [7:0] pos_y,
  output logic       busy,
  output logic       done
);

  localparam int            CW      = $clog2(STEP_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);
  localparam logic [8:0]    STEP9   = 9'(STEP_SIZE);
  localparam logic [7:0]    STEP8   = 8'(STEP_SIZE);
  localparam logic [7:0]    RST8    = 8'(RESET_POS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pos_p;
  logic [7:0]    r_pos_y;
  logic [7:0]    r_tgt_p;
  logic [7:0]    r_tgt_y;
  logic          r_done;

  logic          w_tick;
  logic          w_xfer;
  logic [7:0]    w_nxt_p;
  logic [7:0]    w_nxt_y;

  // One bounded step toward the target; the final step lands exactly on it,
  // so the position never overshoots and never wraps.
  function automatic logic [7:0] f_step(input logic [7:0] pos, input logic [7:0] tgt);
    logic signed [8:0] d;
    logic [8:0]        mag;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    mag = d[8] ? $unsigned(-d) : $unsigned(d);
    if (mag <= STEP9) begin
      return tgt;
    end else if (!d[8]) begin
      return pos + STEP8;
    end else begin
      return pos - STEP8;
    end
  endfunction

  assign w_tick    = (r_cnt == CNT_MAX);
  assign tgt_ready = (r_state == S_IDLE);
  assign w_xfer    = tgt_valid && tgt_ready;
  assign w_nxt_p   = f_step(r_pos_p, r_tgt_p);
  assign w_nxt_y   = f_step(r_pos_y, r_tgt_y);

  assign pos_p = r_pos_p;
  assign pos_y = r_pos_y;
  assign busy  = (r_state == S_RAMP);
  assign done  = r_done;

  // Free-running frame divider; deliberately not resynchronised to target acceptance.
  always_ff @(posedge clk) begin
    if (!resetn || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Ramp FSM: capture targets in IDLE, step both channels per tick in RAMP, pulse done on arrival.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_pos_p <= RST8;
      r_pos_y <= RST8;
      r_tgt_p <= RST8;
      r_tgt_y <= RST8;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A tick coinciding with acceptance is ignored; stepping starts on the next one.
          if (w_xfer) begin
            r_tgt_p <= tgt_p;
            r_tgt_y <= tgt_y;
            if (tgt_p == r_pos_p && tgt_y == r_pos_y) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RAMP;
            end
          end
        end
        S_RAMP: begin
          if (w_tick) begin
            r_pos_p <= w_nxt_p;
            r_pos_y <= w_nxt_y;
            if (w_nxt_p == r_tgt_p && w_nxt_y == r_tgt_y) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/servo_ramp.md
Name: servo_ramp

Overview:
- Upstream slew-rate limiter feeding the two servo pulse generators (pitch and yaw).
- Accepts a target position pair over a valid/ready handshake.
- Moves each 8-bit position output toward its target by a bounded step once per servo frame, so a large target change cannot slam the servo.
- Outputs pos_p and pos_y connect directly to the 8-bit position inputs of the pitch and yaw pulse generators.

Parameters:
- STEP_DIV, 1000000, clk cycles per ramp tick (20 ms at 50 MHz, one servo frame); legal range >= 2.
- STEP_SIZE, 4, maximum position change per tick per channel; legal range 1..255.
- RESET_POS, 0, value loaded into both position outputs on reset; legal range 0..255.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- tgt_valid  in  1  target pair is valid this cycle.
- tgt_ready  out  1  block can accept a target this cycle.
- tgt_p  in  8  pitch target position.
- tgt_y  in  8  yaw target position.
- pos_p  out  8  current pitch position, registered.
- pos_y  out  8  current yaw position, registered.
- busy  out  1  ramp in progress.
- done  out  1  single-cycle pulse when both positions reach their targets.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - pos_p = pos_y = RESET_POS.
  - Target registers = RESET_POS.
  - Tick counter = 0.
  - State = IDLE; busy = 0; done = 0; tgt_ready = 1 from the first cycle after reset.
  - Reset mid-ramp aborts immediately; there is no residual done pulse.
- Tick counter:
  - Free-running 0..STEP_DIV-1, wrapping to 0.
  - tick = 1 only when counter == STEP_DIV-1.
  - The counter is not cleared by target acceptance, so the first step after acceptance lands 1..STEP_DIV cycles later.
- Handshake:
  - Transfer occurs when tgt_valid && tgt_ready at a clk edge.
  - tgt_ready = 1 only in IDLE; tgt_ready is combinational from state.
  - tgt_p and tgt_y are captured into target registers on transfer.
  - tgt_valid while tgt_ready=0 is ignored. The source must hold the request; the block does not queue it.
- State machine (2 states):
  - IDLE:
    - On transfer with tgt_p==pos_p and tgt_y==pos_y: stay in IDLE, done=1 the next cycle.
    - On any other transfer: go to RAMP, busy=1 from the next cycle.
  - RAMP:
    - On each tick, each channel is updated independently.
    - d = target - pos, computed as a 9-bit signed value.
    - If |d| <= STEP_SIZE: pos = target.
    - Else if d > 0: pos = pos + STEP_SIZE.
    - Else: pos = pos - STEP_SIZE.
    - If both channels equal their targets after the update: go to IDLE and assert done for exactly one cycle, in the cycle following the final update.
    - A channel already at its target holds.
- Arithmetic:
  - No wrap-around; pos stays within 0..255 because it never overshoots the target.
  - The last step may be smaller than STEP_SIZE.
- Outputs:
  - pos_p and pos_y change only on tick edges in RAMP, or on reset; they are otherwise stable.
  - busy = (state == RAMP).
- Simultaneous tick and transfer in IDLE: the tick is ignored; the first step uses the next tick.
- Number of ticks to finish = ceil(max(|dP|, |dY|) / STEP_SIZE).

Test Plan:
- Reset: STEP_DIV=10, STEP_SIZE=4, RESET_POS=0; hold resetn=0 for 3 cycles -> pos_p=pos_y=0, busy=0, done=0, tgt_ready=1.
- Basic ramp: send tgt_p=10, tgt_y=0 -> busy next cycle; pos_p goes 4, 8, 10 on three successive ticks (10 cycles apart); pos_y stays 0; one-cycle done after the third tick; tgt_ready returns to 1.
- Downward and mixed ramp: from pos_p=pos_y=10, send tgt_p=0, tgt_y=13 -> tick 1 gives (6,14 clamped to 13? no: 10+4=14 >13 so |d|=3<=4) p=6, y=13; tick 2 gives p=2; tick 3 gives p=0; done pulses once.
- Backpressure: assert tgt_valid with tgt_p=200 during RAMP -> tgt_ready=0, no capture, ramp continues to the old target; holding valid causes acceptance on the first IDLE cycle.
- Null move: send a target equal to the current position -> state stays IDLE, busy stays 0, done=1 on the next cycle only.
- Reset mid-ramp: ramp 0->255; drop resetn after 2 ticks -> next edge gives pos=0, busy=0, counter=0; no done pulse.
